div_unit: RTL and testbench

Iterative 32-bit integer divider that takes over the divide operation from the combinational ALU in the multicycle datapath. It consumes the same SrcA/SrcB operands the ALU receives in the execute step. It stalls the controller through `busy`, and returns quotient and remainder plus NZCV-format flags that are muxed into the ALUResult register and the flag logic. It uses one radix-2 restoring iteration per cycle, supports signed and unsigned division, and handles divide-by-zero deterministically.

---
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider for the multicycle
// datapath. Accepts SrcA/SrcB from the execute step, stalls the controller
// through busy, and returns quotient, remainder and NZCV-style flags.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        divide request, sampled only while busy=0
//   is_signed    1 = two's-complement divide, 0 = unsigned (sampled with start)
//   a, b         dividend / divisor (sampled with start)
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle result-valid pulse
//   quotient     registered quotient, held until the next done
//   remainder    registered remainder, held until the next done
//   div_by_zero  registered divide-by-zero indication
//   DivFlags     {N,Z,C,V} derived from the registered quotient
//
// state  | meaning
// IDLE   | waiting for start; results hold
// RUN    | one restoring iteration per cycle, 32 cycles
// FINISH | sign correction, register results, pulse done
module div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic [3:0]  DivFlags
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state, state_nxt;
  logic [31:0] dvd;       // dividend magnitude, shifts out as quotient bits shift in
  logic [31:0] dvs;       // divisor magnitude
  logic [31:0] prem;      // partial remainder
  logic [4:0]  cnt;
  logic        q_neg, r_neg, dbz_pend;

  logic        accept;
  logic [31:0] a_mag, b_mag;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        qbit;
  logic [31:0] q_raw, r_raw;

  // busy covers the done cycle so a start coincident with done is not taken.
  assign busy   = (state != IDLE) || done;
  assign accept = start && !busy;

  assign a_mag = (is_signed && a[31]) ? -a : a;
  assign b_mag = (is_signed && b[31]) ? -b : b;

  // The shifted partial remainder can reach 33 bits, so the trial subtract
  // carries one extra bit to keep its sign unambiguous.
  assign shifted = {prem, dvd[31]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs};
  assign qbit    = ~trial[33];

  // On divide-by-zero dvd still holds |a|; negating by r_neg restores a.
  assign q_raw = dbz_pend ? 32'hFFFF_FFFF : (q_neg ? -dvd : dvd);
  assign r_raw = dbz_pend ? (r_neg ? -dvd : dvd) : (r_neg ? -prem : prem);

  assign DivFlags = {quotient[31], (quotient == 32'd0), 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (b == 32'd0) ? FINISH : RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_pend    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd      <= a_mag;
            dvs      <= b_mag;
            q_neg    <= is_signed & (a[31] ^ b[31]);
            r_neg    <= is_signed & a[31];
            prem     <= '0;
            cnt      <= '0;
            dbz_pend <= (b == 32'd0);
          end
        end
        RUN: begin
          prem <= qbit ? trial[31:0] : shifted[31:0];
          dvd  <= {dvd[30:0], qbit};
          cnt  <= cnt + 5'd1;
        end
        FINISH: begin
          quotient    <= q_raw;
          remainder   <= r_raw;
          div_by_zero <= dbz_pend;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [3:0]  DivFlags;

  div_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .DivFlags(DivFlags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_cyc = 0;
  int          t_issue = 0;
  logic [31:0] last_q = 0;
  logic [31:0] last_r = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cyc <= busy_cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    exp_t e;
    e.dbz = (bv == 32'd0);
    if (bv == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = av;
    end else if (!sv) begin
      e.q = av / bv;
      e.r = av % bv;
    end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      e.q = $signed(av) / $signed(bv);
      e.r = $signed(av) % $signed(bv);
    end
    return e;
  endfunction

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sv);
    @(negedge clk);
    a = av; b = bv; is_signed = sv; start = 1'b1;
    sb.push_back(model(av, bv, sv));
    @(posedge clk);
    #1;
    t_issue = cyc;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    bit   seen = 0;
    int   hold_err = 0;
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (quotient !== last_q || remainder !== last_r) hold_err++;
    end
    check_val({tag, "_hold"}, hold_err, 0);
    if (!seen) begin
      check_val({tag, "_timeout"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      check_val({tag, "_latency"}, cyc - t_issue, exp_lat);
      e = sb.pop_front();
      check_val({tag, "_q"}, quotient, e.q);
      check_val({tag, "_r"}, remainder, e.r);
      check_val({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      check_val({tag, "_flags"}, {28'd0, DivFlags}, {28'd0, e.q[31], (e.q == 32'd0), 2'b00});
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  initial begin
    int bc0;
    int done_cnt;
    logic [31:0] ra, rb;
    logic        rs;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #2;
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_done", {31'd0, done}, 0);
    check_val("rst_q", quotient, 0);
    check_val("rst_r", remainder, 0);
    check_val("rst_dbz", {31'd0, div_by_zero}, 0);
    check_val("rst_flags", {28'd0, DivFlags}, 32'h4);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // unsigned 100 / 7 with busy length
    #1 bc0 = busy_cyc;
    issue(32'd100, 32'd7, 1'b0);
    wait_done("u100_7", 33);
    check_val("u100_7_qc", quotient, 32'd14);
    check_val("u100_7_rc", remainder, 32'd2);
    check_val("u100_7_fc", {28'd0, DivFlags}, 32'h0);
    @(negedge clk);
    #1;
    check_val("u100_7_busy_low", {31'd0, busy}, 0);
    check_val("u100_7_busy_len", busy_cyc - bc0, 34);

    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("s_m7_2", 33);
    check_val("s_m7_2_qc", quotient, 32'hFFFF_FFFD);
    check_val("s_m7_2_rc", remainder, 32'hFFFF_FFFF);
    check_val("s_m7_2_fc", {28'd0, DivFlags}, 32'h8);

    issue(32'd5, 32'd0, 1'b1);
    wait_done("s_dbz", 1);
    check_val("s_dbz_qc", quotient, 32'hFFFF_FFFF);
    check_val("s_dbz_rc", remainder, 32'd5);

    issue(32'hFFFF_FFF0, 32'd0, 1'b1);
    wait_done("s_dbz_neg", 1);
    issue(32'h8000_0000, 32'd0, 1'b0);
    wait_done("u_dbz", 1);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("s_ovf", 33);
    check_val("s_ovf_qc", quotient, 32'h8000_0000);
    check_val("s_ovf_fc", {28'd0, DivFlags}, 32'h8);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("u_ovf", 33);
    check_val("u_ovf_rc", remainder, 32'h8000_0000);
    check_val("u_ovf_fc", {28'd0, DivFlags}, 32'h4);

    // start while busy is ignored
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd9; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ign", 33);
    check_val("ign_qc", quotient, 32'hFFFF_FFFF);
    check_val("ign_rc", remainder, 32'd0);
    @(negedge clk);
    check_val("ign_no_second", {31'd0, busy}, 0);

    // reset mid-operation
    issue(32'd123456, 32'd7, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("mid_rst_q", quotient, 0);
    check_val("mid_rst_r", remainder, 0);
    check_val("mid_rst_busy", {31'd0, busy}, 0);
    check_val("mid_rst_flags", {28'd0, DivFlags}, 32'h4);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("mid_rst_no_done", done_cnt, 0);
    last_q = 0;
    last_r = 0;

    issue(32'd77, 32'hFFFF_FFF6, 1'b1);
    wait_done("post_rst", 33);

    // back-to-back: next start one cycle after done
    issue(32'd1000, 32'd10, 1'b0);
    wait_done("b2b", 33);
    check_val("b2b_qc", quotient, 32'd100);
    check_val("b2b_rc", remainder, 32'd0);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (k % 3 == 0) rb = -rb;
      rs = k[0];
      issue(ra, rb, rs);
      wait_done("rand", 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
